// File: rtl/mult8x8_pkg.sv
// Shared types and constants for the 8x8 sequential multiplier controller.
// State encodings, mux4 select codes, shifter codes and nibble width.
package mult8x8_pkg;

  localparam int NIB_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LSB  = 3'b001,
    ST_MID  = 3'b010,
    ST_MSB  = 3'b011,
    ST_DONE = 3'b100,
    ST_ERR  = 3'b101
  } state_e;

  localparam logic [1:0] SEL_LL = 2'b00;
  localparam logic [1:0] SEL_LH = 2'b01;
  localparam logic [1:0] SEL_HL = 2'b10;
  localparam logic [1:0] SEL_HH = 2'b11;

  localparam logic [1:0] SH_0  = 2'b00;
  localparam logic [1:0] SH_1N = 2'b01;
  localparam logic [1:0] SH_2N = 2'b10;

endpackage

// File: rtl/mult8x8_ctrl.sv
// Control FSM for the sequential 8x8 multiplier (nibble mux, 4x4 mult, shift, acc).
// Optional MULT_CTRL_ERR_EN: start while busy traps in ERR and adds an err port.
import mult8x8_pkg::*;

module mult8x8_ctrl #(
  parameter int NIB_W   = NIB_W_DEF,
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               op_load,
  output logic [1:0]         sel,
  output logic [1:0]         shift,
  output logic               acc_en,
  output logic               acc_load,
  output logic               busy,
  output logic               done,
`ifdef MULT_CTRL_ERR_EN
  output logic               err,
`endif
  output logic [STATE_W-1:0] state_out
);

  if (NIB_W < 1) begin : g_bad_nib
    $error("NIB_W must be at least 1");
  end

  state_e r_state;
  state_e w_state_nxt;
  logic   r_mid;
  logic   w_mid_nxt;
  logic   w_err;

  // State register and MID sub-step counter; reset abandons any sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mid   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mid   <= w_mid_nxt;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    w_state_nxt = r_state;
    w_mid_nxt   = r_mid;
    sel         = SEL_LL;
    shift       = SH_0;
    acc_en      = 1'b0;
    acc_load    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_LSB;
          w_mid_nxt   = 1'b0;
        end
      end
      ST_LSB: begin
        sel         = SEL_LL;
        shift       = SH_0;
        acc_en      = 1'b1;
        acc_load    = 1'b1;
        busy        = 1'b1;
        w_state_nxt = ST_MID;
        w_mid_nxt   = 1'b0;
      end
      ST_MID: begin
        sel    = r_mid ? SEL_HL : SEL_LH;
        shift  = SH_1N;
        acc_en = 1'b1;
        busy   = 1'b1;
        if (r_mid) begin
          w_state_nxt = ST_MSB;
        end else begin
          w_mid_nxt = 1'b1;
        end
      end
      ST_MSB: begin
        sel         = SEL_HH;
        shift       = SH_2N;
        acc_en      = 1'b1;
        busy        = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          w_state_nxt = ST_LSB;
          w_mid_nxt   = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
`ifdef MULT_CTRL_ERR_EN
      ST_ERR: begin
        w_err = 1'b1;
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_mid_nxt   = 1'b0;
      end
    endcase
`ifdef MULT_CTRL_ERR_EN
    if (busy && start) begin
      w_state_nxt = ST_ERR;
      w_mid_nxt   = 1'b0;
    end
`endif
  end

  // Operand capture is a Mealy pulse so back-to-back runs lose no cycle
  assign op_load =
    start && (r_state == ST_IDLE || r_state == ST_DONE);

  assign state_out = STATE_W'(r_state);

`ifdef MULT_CTRL_ERR_EN
  assign err = w_err;
`else
  logic w_unused;
  assign w_unused = w_err;
`endif

endmodule

// File: tb/tb_mult8x8_ctrl.sv
// Randomized bench for mult8x8_ctrl with a step-count reference model.
// A behavioural datapath driven by the DUT checks each product against a*b.
`timescale 1ns/1ps

module tb_mult8x8_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       op_load;
  logic [1:0] sel;
  logic [1:0] shift;
  logic       acc_en;
  logic       acc_load;
  logic       busy;
  logic       done;
  logic       err_o;
  logic [2:0] state_out;
  logic [7:0] dataa, datab;

  always #5 clk = ~clk;

  mult8x8_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_load   (op_load),
    .sel       (sel),
    .shift     (shift),
    .acc_en    (acc_en),
    .acc_load  (acc_load),
    .busy      (busy),
    .done      (done),
`ifdef MULT_CTRL_ERR_EN
    .err       (err_o),
`endif
    .state_out (state_out)
  );

`ifndef MULT_CTRL_ERR_EN
  assign err_o = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Behavioural datapath: nibble select, 4x4 product, shift, accumulate
  logic [7:0]  ra, rb;
  logic [15:0] acc;
  always @(posedge clk) begin
    logic [3:0]  na, nb;
    logic [15:0] pp;
    na = sel[1] ? ra[7:4] : ra[3:0];
    nb = sel[0] ? rb[7:4] : rb[3:0];
    pp = 16'(na * nb);
    if (shift == 2'b01) pp = pp << 4;
    else if (shift == 2'b10) pp = pp << 8;
    if (acc_en) acc <= acc_load ? pp : acc + pp;
    if (op_load) begin
      ra <= dataa;
      rb <= datab;
    end
  end

  // Reference: step = cycles since operand capture (0 idle, 5 done, 6 err)
  int step = 0;
  logic [15:0] prod_q[$];

  localparam logic [2:0] T_ST[7] = '{0, 1, 2, 2, 3, 4, 5};
  localparam logic [1:0] T_SEL[7] = '{0, 0, 1, 2, 3, 0, 0};
  localparam logic [1:0] T_SH[7] = '{0, 0, 1, 1, 2, 0, 0};
  localparam logic       T_EN[7] = '{0, 1, 1, 1, 1, 0, 0};
  localparam logic       T_LD[7] = '{0, 1, 0, 0, 0, 0, 0};
  localparam logic       T_DN[7] = '{0, 0, 0, 0, 0, 1, 0};
  localparam logic       T_ER[7] = '{0, 0, 0, 0, 0, 0, 1};

  task automatic cycle(input logic s, input logic r,
                       input logic [7:0] a, input logic [7:0] b);
    logic       exp_ol;
    logic [11:0] got_v, exp_v;
    start = s;
    reset = r;
    dataa = a;
    datab = b;
    #2;
    exp_ol = s && (step == 0 || step == 5);
    got_v = {op_load, sel, shift, acc_en, acc_load,
             busy, done, err_o, state_out};
    exp_v = {exp_ol, T_SEL[step], T_SH[step], T_EN[step],
             T_LD[step], T_EN[step], T_DN[step], T_ER[step],
             T_ST[step]};
    chk("ctl", 32'(got_v), 32'(exp_v));
    if (T_DN[step]) begin
      if (prod_q.size() > 0) chk("prod", 32'(acc), 32'(prod_q.pop_front()));
      else chk("prod_q", 32'(prod_q.size()), 32'd1);
    end
    @(posedge clk);
    #1;
    if (r) begin
      step = 0;
      prod_q.delete();
    end else begin
      if (exp_ol) prod_q.push_back(16'(a * b));
      case (step)
        0, 5:    step = s ? 1 : 0;
        1, 2, 3, 4: begin
          step = step + 1;
`ifdef MULT_CTRL_ERR_EN
          if (s) step = 6;
`endif
        end
        default: step = 6;
      endcase
    end
  endtask

  task automatic one_mult(input logic [7:0] a, input logic [7:0] b);
    cycle(1'b1, 1'b0, a, b);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  logic [7:0] opa [4] = '{8'hF0, 8'hFF, 8'h00, 8'h01};
  logic [7:0] opb [4] = '{8'hA5, 8'hFF, 8'hA5, 8'h01};

  initial begin
    start = 1'b0;
    reset = 1'b1;
    dataa = 8'h00;
    datab = 8'h00;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b1, 8'h00, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 4; i++) one_mult(opa[i], opb[i]);

    cycle(1'b1, 1'b0, 8'h12, 8'h34);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 1'b1, 8'h00, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    one_mult(8'h9C, 8'h37);

    for (int i = 0; i < 22; i++)
      cycle(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00);

`ifndef MULT_CTRL_ERR_EN
    cycle(1'b1, 1'b0, 8'h5A, 8'hC3);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 8'h11, 8'h22);
    cycle(1'b1, 1'b0, 8'h33, 8'h44);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00);
`else
    cycle(1'b1, 1'b0, 8'h5A, 8'hC3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 1'b1, 8'h00, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 8'h00);
`endif

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 2) == 0,
            $urandom_range(0, 39) == 0,
            8'($urandom), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
